// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the decimal-digit-stream to binary rebuilder.
//   state_t   : controller states (IDLE, MUL1, MUL2, DONE)
//   DIGIT_MAX : largest legal decimal digit; larger digits are clamped to it
//   SAT_MAX   : value the 8-bit result saturates at
//   ACC_W     : width of the intermediate shift-add datapath
// ---------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [7:0] SAT_MAX   = 8'd255;
    localparam int         ACC_W     = 12;

    // Clamp an incoming digit into the legal decimal range.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/mul_10_step.sv
// ---------------------------------------------------------------------------
// mul_10_step
// Combinational shift-add datapath for one acc = acc*10 + digit step.
// The multiply is split over two cycles by the controller: first the
// acc<<3 term is produced and registered, then it is added to acc<<1 and
// the digit.
//   i_acc   : current 8-bit accumulator
//   i_digit : clamped digit (0..9)
//   i_t     : registered acc<<3 term from the previous cycle
//   o_t     : acc<<3 term, to be registered by the controller
//   o_sat   : new accumulator value, saturated to SAT_MAX
//   o_ovf   : the unsaturated sum exceeded SAT_MAX
// ---------------------------------------------------------------------------
module mul_10_step
    import mul_pkg::*;
(
    input  logic [7:0]       i_acc,
    input  logic [3:0]       i_digit,
    input  logic [ACC_W-1:0] i_t,
    output logic [ACC_W-1:0] o_t,
    output logic [7:0]       o_sat,
    output logic             o_ovf
);

    logic [ACC_W-1:0] w_acc_ext;
    logic [ACC_W-1:0] w_sum;

    assign w_acc_ext = {{(ACC_W-8){1'b0}}, i_acc};
    assign o_t       = w_acc_ext << 3;

    // Worst case 255*10 + 9 = 2559 fits comfortably in ACC_W bits.
    assign w_sum = i_t + (w_acc_ext << 1) + {{(ACC_W-4){1'b0}}, i_digit};

    assign o_ovf = (w_sum > {{(ACC_W-8){1'b0}}, SAT_MAX});
    assign o_sat = o_ovf ? SAT_MAX : w_sum[7:0];

endmodule

// File: rtl/mul_acc_10.sv
// ---------------------------------------------------------------------------
// mul_acc_10
// Rebuilds a binary value from a most-significant-first decimal digit
// stream (acc = acc*10 + digit), saturating at 255.  Each digit takes three
// cycles: accept (IDLE), shift term (MUL1), add/update (MUL2).  After the
// digit flagged last, the result is held in DONE until the consumer takes it.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : digit offered
//   in_ready  : digit accepted this cycle (IDLE only)
//   in_digit  : decimal digit; values above 9 are clamped and flagged
//   in_last   : digit is the final one of the number
//   out_valid : result held (DONE)
//   out_ready : consumer takes the result
//   out       : reconstructed value, saturated to 255
//   out_ovf   : value exceeded 255 at some step
//   out_err   : at least one digit was greater than 9
// ---------------------------------------------------------------------------
module mul_acc_10
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       out_ovf,
    output logic       out_err
);

    state_t           r_state;
    logic [7:0]       r_acc;
    logic [ACC_W-1:0] r_t;
    logic [3:0]       r_digit;
    logic             r_last;
    logic             r_ovf;
    logic             r_err;

    logic [ACC_W-1:0] w_t;
    logic [7:0]       w_sat;
    logic             w_ovf;

    mul_10_step u_step (
        .i_acc   (r_acc),
        .i_digit (r_digit),
        .i_t     (r_t),
        .o_t     (w_t),
        .o_sat   (w_sat),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= 8'd0;
            r_t     <= '0;
            r_digit <= 4'd0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_digit <= clamp_digit(in_digit);
                        r_last  <= in_last;
                        if (in_digit > DIGIT_MAX) begin
                            r_err <= 1'b1;
                        end
                        r_state <= MUL1;
                    end
                end
                MUL1: begin
                    r_t     <= w_t;
                    r_state <= MUL2;
                end
                MUL2: begin
                    // Once saturated, acc*10 always exceeds the limit again,
                    // so the result stays pinned at SAT_MAX.
                    r_acc <= w_sat;
                    if (w_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    r_state <= r_last ? DONE : IDLE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= 8'd0;
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst so it drops immediately while reset is held.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out       = out_valid ? r_acc : 8'd0;
    assign out_ovf   = out_valid ? r_ovf : 1'b0;
    assign out_err   = out_valid ? r_err : 1'b0;

endmodule
